// File: rtl/evaluate_taper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | evaluate_taper_pkg                                                       |
// | Shared taper constants and FSM state encoding.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package evaluate_taper_pkg;

  localparam int TAPER_PHASE_MAX   = 256;
  localparam int TAPER_PHASE_SHIFT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PHASE = 3'd1,
    ST_MULT  = 3'd2,
    ST_SUM   = 3'd3,
    ST_SIGN  = 3'd4,
    ST_DONE  = 3'd5
  } taper_state_t;

endpackage
`default_nettype wire

// File: rtl/evaluate_taper_phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | evaluate_taper_phase                                                     |
// | Combinational game phase (0..256) from combined non-king material.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module evaluate_taper_phase
  import evaluate_taper_pkg::*;
#(
  parameter int MATERIAL_WIDTH = 32,
  parameter int PHASE_MAT_MAX  = 4096
) (
  input  logic [MATERIAL_WIDTH-1:0] material_white,
  input  logic [MATERIAL_WIDTH-1:0] material_black,
  output logic [8:0]                phase
);

  localparam int c_shift = $clog2(PHASE_MAT_MAX) - TAPER_PHASE_SHIFT;
  localparam logic [MATERIAL_WIDTH:0] c_mat_max = (MATERIAL_WIDTH+1)'(PHASE_MAT_MAX);

  logic [MATERIAL_WIDTH:0] w_total;
  logic [MATERIAL_WIDTH:0] w_clamp;

  // Extra carry bit keeps two huge totals from wrapping below the clamp.
  assign w_total = {1'b0, material_white} + {1'b0, material_black};
  assign w_clamp = (w_total >= c_mat_max) ? c_mat_max : w_total;
  assign phase   = 9'(w_clamp >> c_shift);

endmodule
`default_nettype wire

// File: rtl/evaluate_taper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | evaluate_taper                                                           |
// | Tapered mg/eg blend, draw forcing and side-to-move conversion.           |
// | Optional macro: EVALUATE_TAPER_CONTEMPT_EN (adds contempt draw offset).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module evaluate_taper
  import evaluate_taper_pkg::*;
#(
  parameter int EVAL_WIDTH     = 32,
  parameter int MATERIAL_WIDTH = 32,
  parameter int PHASE_MAT_MAX  = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      eval_valid,
  input  logic [EVAL_WIDTH-1:0]     eval_mg,
  input  logic [EVAL_WIDTH-1:0]     eval_eg,
  input  logic [MATERIAL_WIDTH-1:0] material_white,
  input  logic [MATERIAL_WIDTH-1:0] material_black,
  input  logic                      insufficient_material,
  input  logic                      white_to_move,
  input  logic                      clear_eval,
`ifdef EVALUATE_TAPER_CONTEMPT_EN
  input  logic [EVAL_WIDTH-1:0]     contempt,
`endif
  output logic                      taper_valid,
  output logic [EVAL_WIDTH-1:0]     taper_eval,
  output logic [8:0]                phase
);

  localparam int c_prod_w = EVAL_WIDTH + 10;
  localparam logic [EVAL_WIDTH-1:0] c_eval_max = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic [EVAL_WIDTH-1:0] c_eval_min = {1'b1, {(EVAL_WIDTH-1){1'b0}}};

  function automatic logic [EVAL_WIDTH-1:0] sat_neg(input logic [EVAL_WIDTH-1:0] v);
    return (v == c_eval_min) ? c_eval_max : ('0 - v);
  endfunction

  taper_state_t r_state, w_next;
  logic                        w_capture;
  logic                        r_valid_d;
  logic signed [EVAL_WIDTH-1:0] r_mg, r_eg, r_blend;
  logic [MATERIAL_WIDTH-1:0]   r_mat_w, r_mat_b;
  logic                        r_insuff, r_wtm;
  logic [8:0]                  r_phase, w_phase, w_phase_inv;
  logic signed [c_prod_w-1:0]  r_pmg, r_peg, w_pmg, w_peg, w_sum;
  logic signed [EVAL_WIDTH-1:0] w_blend;
  logic [EVAL_WIDTH-1:0]       w_draw, w_result;
`ifdef EVALUATE_TAPER_CONTEMPT_EN
  logic [EVAL_WIDTH-1:0]       r_contempt;
`endif

  evaluate_taper_phase #(
    .MATERIAL_WIDTH (MATERIAL_WIDTH),
    .PHASE_MAT_MAX  (PHASE_MAT_MAX)
  ) u_phase (
    .material_white (r_mat_w),
    .material_black (r_mat_b),
    .phase          (w_phase)
  );

  assign w_phase_inv = 9'(TAPER_PHASE_MAX) - r_phase;
  assign w_pmg   = c_prod_w'(r_mg) * c_prod_w'($signed({1'b0, r_phase}));
  assign w_peg   = c_prod_w'(r_eg) * c_prod_w'($signed({1'b0, w_phase_inv}));
  assign w_sum   = r_pmg + r_peg;
  assign w_blend = EVAL_WIDTH'(w_sum >>> TAPER_PHASE_SHIFT);

`ifdef EVALUATE_TAPER_CONTEMPT_EN
  assign w_draw = sat_neg(r_contempt);
`else
  assign w_draw = '0;
`endif

  always_comb begin
    w_result = r_blend;
    if (r_insuff) w_result = w_draw;
    else if (!r_wtm) w_result = sat_neg(r_blend);
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (eval_valid && !r_valid_d) begin
          w_next    = ST_PHASE;
          w_capture = 1'b1;
        end
      end
      ST_PHASE: w_next = ST_MULT;
      ST_MULT:  w_next = ST_SUM;
      ST_SUM:   w_next = ST_SIGN;
      ST_SIGN:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
    // Clear wins over a start edge seen in the same cycle.
    if (clear_eval) begin
      w_next    = ST_IDLE;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid_d   <= 1'b0;
      r_mg        <= '0;
      r_eg        <= '0;
      r_mat_w     <= '0;
      r_mat_b     <= '0;
      r_insuff    <= 1'b0;
      r_wtm       <= 1'b0;
      r_phase     <= '0;
      r_pmg       <= '0;
      r_peg       <= '0;
      r_blend     <= '0;
      taper_valid <= 1'b0;
      taper_eval  <= '0;
      phase       <= '0;
`ifdef EVALUATE_TAPER_CONTEMPT_EN
      r_contempt  <= '0;
`endif
    end else begin
      r_valid_d <= eval_valid;
      if (w_capture) begin
        r_mg     <= eval_mg;
        r_eg     <= eval_eg;
        r_mat_w  <= material_white;
        r_mat_b  <= material_black;
        r_insuff <= insufficient_material;
        r_wtm    <= white_to_move;
`ifdef EVALUATE_TAPER_CONTEMPT_EN
        r_contempt <= contempt;
`endif
      end
      if (r_state == ST_PHASE) r_phase <= w_phase;
      if (r_state == ST_MULT) begin
        r_pmg <= w_pmg;
        r_peg <= w_peg;
      end
      if (r_state == ST_SUM) r_blend <= w_blend;
      if (clear_eval) begin
        taper_valid <= 1'b0;
      end else if (r_state == ST_SIGN) begin
        taper_valid <= 1'b1;
        taper_eval  <= w_result;
        phase       <= r_phase;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_evaluate_taper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_evaluate_taper                                                        |
// | Directed self-checking bench for evaluate_taper.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_evaluate_taper;

  logic        clk = 1'b0;
  logic        reset;
  logic        eval_valid;
  logic [31:0] eval_mg, eval_eg, material_white, material_black;
  logic        insufficient_material, white_to_move, clear_eval;
  logic        taper_valid;
  logic [31:0] taper_eval;
  logic [8:0]  phase;
`ifdef EVALUATE_TAPER_CONTEMPT_EN
  logic [31:0] contempt = 32'd25;
  localparam logic [31:0] c_draw = 32'hFFFF_FFE7;
`else
  localparam logic [31:0] c_draw = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  evaluate_taper dut (
    .clk                   (clk),
    .reset                 (reset),
    .eval_valid            (eval_valid),
    .eval_mg               (eval_mg),
    .eval_eg               (eval_eg),
    .material_white        (material_white),
    .material_black        (material_black),
    .insufficient_material (insufficient_material),
    .white_to_move         (white_to_move),
    .clear_eval            (clear_eval),
`ifdef EVALUATE_TAPER_CONTEMPT_EN
    .contempt              (contempt),
`endif
    .taper_valid           (taper_valid),
    .taper_eval            (taper_eval),
    .phase                 (phase)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Clears, raises eval_valid and returns the number of edges until taper_valid.
  task automatic do_eval(input logic [31:0] mg, eg, mw, mb, input logic ins, wtm,
                         output int lat);
    eval_valid = 1'b0; clear_eval = 1'b1; tick();
    clear_eval = 1'b0; tick();
    eval_mg = mg; eval_eg = eg; material_white = mw; material_black = mb;
    insufficient_material = ins; white_to_move = wtm; eval_valid = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        eval_mg = 32'd12345; eval_eg = 32'd999; material_white = 32'd7;
        insufficient_material = ~ins; white_to_move = ~wtm;
      end
      if (taper_valid) begin lat = i; break; end
    end
    eval_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; eval_valid = 1'b1; clear_eval = 1'b0;
    eval_mg = 32'd100; eval_eg = 32'd200; material_white = 0; material_black = 0;
    insufficient_material = 0; white_to_move = 1;
    repeat (3) tick();
    checks++; if (taper_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", taper_valid); end
    checks++; if (taper_eval !== 32'd0) begin errors++; $display("FAIL reset_eval got %0d want 0", taper_eval); end
    checks++; if (phase !== 9'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    eval_valid = 1'b0; reset = 1'b1; tick();
  endtask

  task automatic test_blend();
    int lat;
    do_eval(32'd100, 32'd200, 32'd0, 32'd0, 1'b0, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL eg_only_latency got %0d want 5", lat); end
    checks++; if (taper_eval !== 32'd200) begin errors++; $display("FAIL eg_only_eval got %0d want 200", $signed(taper_eval)); end
    checks++; if (phase !== 9'd0) begin errors++; $display("FAIL eg_only_phase got %0d want 0", phase); end
    do_eval(32'd100, 32'd200, 32'd3000, 32'd3000, 1'b0, 1'b1, lat);
    checks++; if (phase !== 9'd256) begin errors++; $display("FAIL clamp_phase got %0d want 256", phase); end
    checks++; if (taper_eval !== 32'd100) begin errors++; $display("FAIL clamp_eval got %0d want 100", $signed(taper_eval)); end
    do_eval(32'd100, 32'd200, 32'd3000, 32'd3000, 1'b0, 1'b0, lat);
    checks++; if (taper_eval !== 32'(-100)) begin errors++; $display("FAIL clamp_black got %0d want -100", $signed(taper_eval)); end
    do_eval(32'd100, 32'd200, 32'd1024, 32'd1024, 1'b0, 1'b1, lat);
    checks++; if (phase !== 9'd128) begin errors++; $display("FAIL half_phase got %0d want 128", phase); end
    checks++; if (taper_eval !== 32'd150) begin errors++; $display("FAIL half_eval got %0d want 150", $signed(taper_eval)); end
    do_eval(32'hFFFF_FFFF, 32'd0, 32'd1024, 32'd1024, 1'b0, 1'b1, lat);
    checks++; if (taper_eval !== 32'hFFFF_FFFF) begin errors++; $display("FAIL floor_white got %0d want -1", $signed(taper_eval)); end
    do_eval(32'hFFFF_FFFF, 32'd0, 32'd1024, 32'd1024, 1'b0, 1'b0, lat);
    checks++; if (taper_eval !== 32'd1) begin errors++; $display("FAIL floor_black got %0d want 1", $signed(taper_eval)); end
  endtask

  task automatic test_boundaries();
    int lat;
    do_eval(32'd256, 32'd0, 32'd4095, 32'd0, 1'b0, 1'b1, lat);
    checks++; if (phase !== 9'd255) begin errors++; $display("FAIL below_max_phase got %0d want 255", phase); end
    checks++; if (taper_eval !== 32'd255) begin errors++; $display("FAIL below_max_eval got %0d want 255", $signed(taper_eval)); end
    do_eval(32'd7, 32'd9, 32'd4000, 32'd96, 1'b0, 1'b1, lat);
    checks++; if (phase !== 9'd256) begin errors++; $display("FAIL at_max_phase got %0d want 256", phase); end
    do_eval(32'd7, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, lat);
    checks++; if (phase !== 9'd256 || taper_eval !== 32'd7) begin errors++; $display("FAIL carry_clamp got %0d/%0d want 256/7", phase, taper_eval); end
    do_eval(32'h8000_0000, 32'h8000_0000, 32'd1024, 32'd1024, 1'b0, 1'b0, lat);
    checks++; if (taper_eval !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_neg got %h want 7fffffff", taper_eval); end
    do_eval(32'h8000_0000, 32'h8000_0000, 32'd1024, 32'd1024, 1'b0, 1'b1, lat);
    checks++; if (taper_eval !== 32'h8000_0000) begin errors++; $display("FAIL min_white got %h want 80000000", taper_eval); end
  endtask

  task automatic test_draw();
    int lat;
    do_eval(32'd500, 32'd500, 32'd1024, 32'd1024, 1'b1, 1'b1, lat);
    checks++; if (taper_eval !== c_draw) begin errors++; $display("FAIL draw_eval got %0d want %0d", $signed(taper_eval), $signed(c_draw)); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL draw_latency got %0d want 5", lat); end
  endtask

  task automatic test_held_high();
    int rises = 0;
    logic prev = 1'b0;
    eval_valid = 1'b0; clear_eval = 1'b1; tick(); clear_eval = 1'b0; tick();
    eval_mg = 32'd100; eval_eg = 32'd200; material_white = 0; material_black = 0;
    insufficient_material = 0; white_to_move = 1; eval_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      clear_eval = (i == 8);
      tick();
      if (taper_valid && !prev) rises++;
      prev = taper_valid;
    end
    clear_eval = 1'b0;
    checks++; if (rises !== 1) begin errors++; $display("FAIL held_high_results got %0d want 1", rises); end
    checks++; if (taper_valid !== 1'b0) begin errors++; $display("FAIL held_high_retrigger got %0b want 0", taper_valid); end
    eval_valid = 1'b0; tick();
  endtask

  task automatic test_clear_in_mult();
    int lat;
    int seen = 0;
    do_eval(32'd100, 32'd200, 32'd1024, 32'd1024, 1'b0, 1'b1, lat);
    eval_valid = 1'b0; clear_eval = 1'b1; tick(); clear_eval = 1'b0; tick();
    eval_mg = 32'd40; eval_eg = 32'd40; eval_valid = 1'b1;
    tick(); tick();
    clear_eval = 1'b1; tick(); clear_eval = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (taper_valid) seen++; end
    eval_valid = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL clear_mult_valid got %0d cycles want 0", seen); end
    checks++; if (taper_eval !== 32'd150 || phase !== 9'd128) begin errors++; $display("FAIL clear_hold got %0d/%0d want 150/128", taper_eval, phase); end
  endtask

  task automatic test_reset_in_sum();
    int seen = 0;
    eval_valid = 1'b0; clear_eval = 1'b1; tick(); clear_eval = 1'b0; tick();
    eval_mg = 32'd100; eval_eg = 32'd200; eval_valid = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0; tick();
    checks++; if (taper_valid !== 1'b0 || taper_eval !== 32'd0 || phase !== 9'd0) begin
      errors++; $display("FAIL reset_sum got %0b/%0d/%0d want 0/0/0", taper_valid, taper_eval, phase);
    end
    eval_valid = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); if (taper_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_abort got %0d cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    eval_valid = 1'b0; clear_eval = 1'b1; tick(); clear_eval = 1'b0;
    eval_mg = 32'd10; eval_eg = 32'd30; material_white = 32'd2048; material_black = 32'd0;
    insufficient_material = 0; white_to_move = 1; eval_valid = 1'b1;
    repeat (4) tick();
    checks++; if (taper_valid !== 1'b0) begin errors++; $display("FAIL reraise_early got %0b want 0", taper_valid); end
    tick();
    checks++; if (taper_valid !== 1'b1) begin errors++; $display("FAIL reraise_valid got %0b want 1", taper_valid); end
    checks++; if (taper_eval !== 32'd20) begin errors++; $display("FAIL reraise_eval got %0d want 20", $signed(taper_eval)); end
    eval_valid = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_blend();
    test_boundaries();
    test_draw();
    test_held_high();
    test_clear_in_mult();
    test_reset_in_sum();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
